alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 67 ++++++
 tb/tb_alu.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Single-cycle registered ALU: eight unsigned operations, modulo 2^WIDTH,
// with a zero flag registered alongside the result.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_out,
  output logic             z
);

  logic [WIDTH-1:0]   alu_out_d;
  logic [WIDTH-1:0]   alu_out_q;
  logic               z_d;
  logic               z_q;
  logic [2*WIDTH-1:0] prod_s;

  // Full-width product; only the low half is kept as the result.
  assign prod_s = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};

  // Next-result decode; division by zero yields all-ones and modulo by zero yields in1.
  always_comb begin
    alu_out_d = '0;
    case (alu_op)
      3'd0:    alu_out_d = in1 + in2;
      3'd1:    alu_out_d = in1 - in2;
      3'd2:    alu_out_d = prod_s[WIDTH-1:0];
      3'd3:    alu_out_d = in1 << in2[3:0];
      3'd4: begin
        if (in2 == '0) begin
          alu_out_d = '1;
        end else begin
          alu_out_d = in1 / in2;
        end
      end
      3'd5: begin
        if (in2 == '0) begin
          alu_out_d = in1;
        end else begin
          alu_out_d = in1 % in2;
        end
      end
      3'd6:    alu_out_d = in1;
      3'd7:    alu_out_d = in2;
      default: alu_out_d = '0;
    endcase
    z_d = (alu_out_d == '0);
  end

  // Result and flag registered on the same edge so they never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_out_q <= '0;
      z_q       <= 1'b1;
    end else begin
      alu_out_q <= alu_out_d;
      z_q       <= z_d;
    end
  end

  assign alu_out = alu_out_q;
  assign z       = z_q;

endmodule

// File: tb/tb_alu.sv
// Randomized and directed checks of alu against an arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [2:0]  alu_op;
  logic [15:0] alu_out;
  logic        z;

  int n_pass;
  int n_total;

  alu #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .in1    (in1),
    .in2    (in2),
    .alu_op (alu_op),
    .alu_out(alu_out),
    .z      (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference computed with plain integer arithmetic, reduced modulo 2^16.
  function automatic logic [15:0] ref_alu(input int op, input longint a, input longint b);
    longint r;
    case (op)
      0: r = (a + b) % 65536;
      1: r = (a - b + 65536) % 65536;
      2: r = (a * b) % 65536;
      3: r = (a * (64'sd1 << (b % 16))) % 65536;
      4: r = (b == 0) ? 65535 : a / b;
      5: r = (b == 0) ? a : a % b;
      6: r = a;
      default: r = b;
    endcase
    return r[15:0];
  endfunction

  // Called at a negedge: drive inputs, let one posedge pass, check at the next negedge.
  task automatic op_check(input string tag, input int op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] exp;
    alu_op = op[2:0];
    in1    = a;
    in2    = b;
    exp    = ref_alu(op, longint'(a), longint'(b));
    @(negedge clk);
    check({tag, "_out"}, {16'd0, alu_out}, {16'd0, exp});
    check({tag, "_z"}, {31'd0, z}, {31'd0, (exp == 16'd0)});
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    in1     = 16'h1234;
    in2     = 16'h0003;
    alu_op  = 3'd0;
    #1;
    check("rst_async_out", {16'd0, alu_out}, 32'd0);
    check("rst_async_z", {31'd0, z}, 32'd1);
    // Outputs must hold reset values across edges while reset is high.
    repeat (3) begin
      @(negedge clk);
      in1 = 16'($urandom);
      check("rst_hold_out", {16'd0, alu_out}, 32'd0);
      check("rst_hold_z", {31'd0, z}, 32'd1);
    end
    reset = 1'b0;

    // Successive ops on 6 and 2.
    for (int op = 0; op < 8; op++) begin
      op_check($sformatf("seq_op%0d", op), op, 16'd6, 16'd2);
    end

    op_check("div_small", 4, 16'd2, 16'd4);
    op_check("sub_wrap", 1, 16'd2, 16'd4);
    op_check("add_wrap", 0, 16'hFFFF, 16'd1);
    op_check("mul_wrap", 2, 16'h8000, 16'd2);
    op_check("div_zero", 4, 16'd7, 16'd0);
    op_check("mod_zero", 5, 16'd7, 16'd0);
    op_check("shl_mask", 3, 16'd1, 16'h0013);

    // Inputs changing between edges must not disturb the registered output.
    in1    = 16'h00FF;
    in2    = 16'h0000;
    alu_op = 3'd6;
    #2;
    check("hold_between_out", {16'd0, alu_out}, 32'd8);
    check("hold_between_z", {31'd0, z}, 32'd0);

    // Asynchronous reset between edges while alu_out = 8.
    reset = 1'b1;
    #1;
    check("mid_rst_out", {16'd0, alu_out}, 32'd0);
    check("mid_rst_z", {31'd0, z}, 32'd1);
    in1    = 16'd9;
    in2    = 16'd5;
    alu_op = 3'd0;
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_out", {16'd0, alu_out}, 32'd14);
    check("post_rst_z", {31'd0, z}, 32'd0);

    // Randomized traffic, with extra weight on zero and small divisors.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      int          op;
      op = int'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'd0;
        1: b = 16'($urandom_range(0, 20));
        2: a = b;
        default: a = a;
      endcase
      op_check($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
